q_word_packer: RTL

Downstream consumer of the registered AND/OR logic cell: samples its single-bit Q output on qualified cycles and packs consecutive bits into WIDTH-bit words. Each completed word is presented on a valid/ready output port together with its population count. One completed word may wait in the shift register while another sits in the output register; bits that arrive while both are occupied are dropped and flagged.

---
 rtl/q_word_packer_if.sv | 21 ++
 rtl/q_word_packer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/q_word_packer_if.sv
// q_word_packer_if
//   Output word port of q_word_packer: a packed word and its population
//   count, presented with a valid/ready handshake.
//   Word   : packed word, first sampled bit in Word[0]
//   Ones   : number of 1s in Word
//   W_vld  : Word/Ones valid (driven by the packer)
//   W_rdy  : consumer accepts the word (driven by the consumer)
//   master : packer side; slave : consumer side
interface q_word_packer_if #(
  parameter int WIDTH = 8
) ();
  localparam int OW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] Word;
  logic [OW-1:0]    Ones;
  logic             W_vld;
  logic             W_rdy;

  modport master (output Word, output Ones, output W_vld, input W_rdy);
  modport slave  (input Word, input Ones, input W_vld, output W_rdy);
endinterface

// File: rtl/q_word_packer.sv
// q_word_packer
//   Samples the logic cell's Q output on qualified cycles and packs
//   consecutive bits into WIDTH-bit words, first bit in Word[0]. Completed
//   words leave through a valid/ready port together with their ones count.
//   One completed word may wait in the shift register (HOLD) while another
//   occupies the output register; samples arriving in HOLD are dropped and
//   flagged on the sticky Ovf.
//   CLK    : clock, rising edge
//   Clr    : asynchronous active-high reset
//   Q_in   : data bit from the logic cell
//   Q_vld  : Q_in is a new sample this cycle
//   Start  : begin packing, clear Ovf (IDLE only)
//   Stop   : abort packing, discard partial or held word
//   Busy   : state != IDLE (registered)
//   Ovf    : sticky, a sample was dropped since the last Start
//   wp     : output word port (Word, Ones, W_vld, W_rdy)
module q_word_packer #(
  parameter int WIDTH = 8
) (
  input  logic            CLK,
  input  logic            Clr,
  input  logic            Q_in,
  input  logic            Q_vld,
  input  logic            Start,
  input  logic            Stop,
  output logic            Busy,
  output logic            Ovf,
  q_word_packer_if.master wp
);
  localparam int OW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    cnt;
  logic [OW-1:0]    acc;
  logic [OW-1:0]    acc_nxt;
  logic [WIDTH-1:0] word_q;
  logic [OW-1:0]    ones_q;
  logic             wvld_q;
  logic             xfer;
  logic             out_free;

  // acc never exceeds WIDTH, so the plain add cannot overflow OW bits
  function automatic logic [OW-1:0] add_bit(input logic [OW-1:0] a, input logic b);
    return a + OW'(b);
  endfunction

  assign sr_nxt   = {Q_in, sr[WIDTH-1:1]};
  assign acc_nxt  = add_bit(acc, Q_in);
  assign xfer     = wvld_q & wp.W_rdy;
  assign out_free = ~wvld_q | wp.W_rdy;

  assign wp.Word  = word_q;
  assign wp.Ones  = ones_q;
  assign wp.W_vld = wvld_q;

  always_ff @(posedge CLK or posedge Clr) begin
    if (Clr) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      acc    <= '0;
      word_q <= '0;
      ones_q <= '0;
      wvld_q <= 1'b0;
      Ovf    <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      // a transfer empties the output register unless a load below refills it
      if (xfer) wvld_q <= 1'b0;

      case (state)
        IDLE: begin
          if (Start && !Stop) begin
            state <= COLLECT;
            Busy  <= 1'b1;
            sr    <= '0;
            cnt   <= '0;
            acc   <= '0;
            Ovf   <= 1'b0;
          end
        end

        COLLECT: begin
          if (Stop) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
          end else if (Q_vld) begin
            sr <= sr_nxt;
            if (cnt == LAST) begin
              if (out_free) begin
                word_q <= sr_nxt;
                ones_q <= acc_nxt;
                wvld_q <= 1'b1;
                cnt    <= '0;
                acc    <= '0;
              end else begin
                // completed word parks in sr/acc until the output frees up
                acc   <= acc_nxt;
                state <= HOLD;
              end
            end else begin
              cnt <= cnt + 1'b1;
              acc <= acc_nxt;
            end
          end
        end

        HOLD: begin
          if (Stop) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
          end else begin
            if (Q_vld) Ovf <= 1'b1;
            if (xfer) begin
              word_q <= sr;
              ones_q <= acc;
              wvld_q <= 1'b1;
              cnt    <= '0;
              acc    <= '0;
              state  <= COLLECT;
            end
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
